unpacked_row_buffer: RTL

UNPACKED_ROW_BUFFER -- requirements
Module: unpacked_row_buffer

---
 rtl/row_buf_pkg.sv | 9 +
 rtl/unpacked_row_buffer.sv | 59 +++++
 2 files changed

// File: rtl/row_buf_pkg.sv
// row_buf_pkg: default geometry of the row buffer and the occupancy-count width helper.
package row_buf_pkg;
   localparam int ROWS_DEF = 4;
   localparam int COLS_DEF = 8;
   localparam int W_DEF    = 8;
   function automatic int rf_width(input int rows);
      return $clog2(rows + 1);
   endfunction
endpackage

// File: rtl/unpacked_row_buffer.sv
// unpacked_row_buffer: gathers W-bit elements into COLS-wide rows held in a ROWS-deep unpacked array.
// Optional out_parity port when UNPACKED_ROW_BUFFER_PARITY_EN is defined.
module unpacked_row_buffer
   import row_buf_pkg::*;
#(
   parameter int ROWS = ROWS_DEF,
   parameter int COLS = COLS_DEF,
   parameter int W    = W_DEF
)(
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [W-1:0]                in_data,
   input  logic                        flush,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [COLS*W-1:0]           out_row,
   output logic [rf_width(ROWS)-1:0]   rows_full
`ifdef UNPACKED_ROW_BUFFER_PARITY_EN
   ,
   output logic                        out_parity
`endif
);
   localparam int CW = rf_width(ROWS);
   localparam int RW = $clog2(ROWS);
   localparam int KW = $clog2(COLS);
   logic [W-1:0]  mem [ROWS][COLS];
   logic [RW-1:0] wr_row, rd_row;
   logic [KW-1:0] wr_col;
   logic          acc, pop, done;
   assign in_ready  = rows_full < CW'(ROWS);
   assign out_valid = rows_full != '0;
   assign acc       = in_valid && in_ready && !flush;
   assign pop       = out_valid && out_ready;
   assign done      = acc && wr_col == KW'(COLS - 1);
   // Gating with out_valid keeps stale mem contents invisible after reset.
   for (genvar c = 0; c < COLS; c++) begin : g_col
      assign out_row[c*W +: W] = out_valid ? mem[rd_row][c] : '0;
   end
`ifdef UNPACKED_ROW_BUFFER_PARITY_EN
   assign out_parity = ^out_row;
`endif
   always_ff @(posedge clk)
      if (acc) mem[wr_row][wr_col] <= in_data;
   always_ff @(posedge clk)
      if (!rst_n) begin
         wr_row    <= '0;
         wr_col    <= '0;
         rd_row    <= '0;
         rows_full <= '0;
      end else begin
         if (flush) wr_col <= '0;
         else if (acc) wr_col <= done ? '0 : wr_col + 1'b1;
         if (done) wr_row <= wr_row == RW'(ROWS - 1) ? '0 : wr_row + 1'b1;
         if (pop) rd_row <= rd_row == RW'(ROWS - 1) ? '0 : rd_row + 1'b1;
         rows_full <= rows_full + CW'(done) - CW'(pop);
      end
endmodule
